// File: rtl/lut_loader_pkg.sv
// Shared definitions for the LUT table loader: state encoding, counter sizing
// and the word-counter to datapath-address mapping.
package lut_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } ld_state_e;

  localparam int LUT_DEPTH   = 256;
  localparam int TBL_SEL_BIT = 8;
  localparam int TOTAL_WORDS = 2 * LUT_DEPTH;
  localparam int CNT_W       = $clog2(TOTAL_WORDS);

  // Table 0 lives in the upper half of the config space, table 1 in the lower.
  function automatic logic [8:0] tbl_map(input logic [CNT_W-1:0] cnt);
    return {~cnt[TBL_SEL_BIT], cnt[TBL_SEL_BIT-1:0]};
  endfunction

endpackage

// File: rtl/lut_loader_fsm.sv
// Load sequencer: fetches each table word from memory, then writes it to the
// datapath config port, walking both tables with a single word counter.
module lut_loader_fsm
  import lut_loader_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SRC_ADDR_W = 32,
  parameter int TBL_WORDS  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [SRC_ADDR_W-1:0] base_i,
  input  logic                  src_ready_i,
  input  logic [DATA_W-1:0]     src_rdata_i,
  input  logic                  tbl_ready_i,
  output logic                  idle_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  run_o,
  output logic                  src_valid_o,
  output logic [SRC_ADDR_W-1:0] src_addr_o,
  output logic                  tbl_valid_o,
  output logic [8:0]            tbl_addr_o,
  output logic [DATA_W/8-1:0]   tbl_wstrb_o,
  output logic [DATA_W-1:0]     tbl_wdata_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * TBL_WORDS - 1);

  ld_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [SRC_ADDR_W-1:0] base_q, base_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      base_q  <= base_d;
    end
  end

  // Base is captured at start so the request address cannot move mid-load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RD;
          cnt_d   = '0;
          base_d  = base_i;
        end
      end
      ST_RD: begin
        if (src_ready_i) begin
          data_d  = src_rdata_i;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        if (tbl_ready_i) begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ST_RD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle_o      = (state_q == ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_DONE);
    run_o       = (state_q == ST_DONE);
    src_valid_o = (state_q == ST_RD);
    src_addr_o  = (state_q == ST_RD) ? base_q + SRC_ADDR_W'({cnt_q, 2'b00}) : '0;
    tbl_valid_o = (state_q == ST_WR);
    tbl_addr_o  = tbl_map(cnt_q);
    tbl_wstrb_o = (state_q == ST_WR) ? '1 : '0;
    tbl_wdata_o = data_q;
  end

endmodule

// File: rtl/lut_table_loader.sv
// Fills both datapath lookup tables from memory on request; while idle the
// host config port is passed straight through to the datapath.
module lut_table_loader
  import lut_loader_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SRC_ADDR_W = 32,
  parameter int TBL_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SRC_ADDR_W-1:0] base,
  output logic                  busy,
  output logic                  done,
  output logic                  run,
  output logic                  src_valid,
  output logic [SRC_ADDR_W-1:0] src_addr,
  input  logic                  src_ready,
  input  logic [DATA_W-1:0]     src_rdata,
  input  logic                  host_valid,
  input  logic [8:0]            host_addr,
  input  logic [DATA_W/8-1:0]   host_wstrb,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic                  host_ready,
  output logic [DATA_W-1:0]     host_rdata,
  output logic                  tbl_valid,
  output logic [8:0]            tbl_addr,
  output logic [DATA_W/8-1:0]   tbl_wstrb,
  output logic [DATA_W-1:0]     tbl_wdata,
  input  logic                  tbl_ready,
  input  logic [DATA_W-1:0]     tbl_rdata
);

  logic                ld_idle;
  logic                ld_tbl_valid;
  logic [8:0]          ld_tbl_addr;
  logic [DATA_W/8-1:0] ld_tbl_wstrb;
  logic [DATA_W-1:0]   ld_tbl_wdata;

  lut_loader_fsm #(
    .DATA_W     (DATA_W),
    .SRC_ADDR_W (SRC_ADDR_W),
    .TBL_WORDS  (TBL_WORDS)
  ) u_fsm (
    .clk_i       (clk),
    .rst_ni      (rst),
    .start_i     (start),
    .base_i      (base),
    .src_ready_i (src_ready),
    .src_rdata_i (src_rdata),
    .tbl_ready_i (tbl_ready),
    .idle_o      (ld_idle),
    .busy_o      (busy),
    .done_o      (done),
    .run_o       (run),
    .src_valid_o (src_valid),
    .src_addr_o  (src_addr),
    .tbl_valid_o (ld_tbl_valid),
    .tbl_addr_o  (ld_tbl_addr),
    .tbl_wstrb_o (ld_tbl_wstrb),
    .tbl_wdata_o (ld_tbl_wdata)
  );

  // Host owns the config port only while idle; otherwise it is held off.
  always_comb begin
    if (ld_idle) begin
      tbl_valid  = host_valid;
      tbl_addr   = host_addr;
      tbl_wstrb  = host_wstrb;
      tbl_wdata  = host_wdata;
      host_ready = tbl_ready;
      host_rdata = tbl_rdata;
    end else begin
      tbl_valid  = ld_tbl_valid;
      tbl_addr   = ld_tbl_addr;
      tbl_wstrb  = ld_tbl_wstrb;
      tbl_wdata  = ld_tbl_wdata;
      host_ready = 1'b0;
      host_rdata = '0;
    end
  end

endmodule

// File: tb/tb_lut_table_loader.sv
// Directed bench for lut_table_loader: memory/datapath responders with optional
// wait states, write-sequence logging and host passthrough/stall checks.
module tb_lut_table_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base;
  logic        busy, done, run;
  logic        src_valid;
  logic [31:0] src_addr;
  logic        src_ready;
  logic [31:0] src_rdata;
  logic        host_valid;
  logic [8:0]  host_addr;
  logic [3:0]  host_wstrb;
  logic [31:0] host_wdata;
  logic        host_ready;
  logic [31:0] host_rdata;
  logic        tbl_valid;
  logic [8:0]  tbl_addr;
  logic [3:0]  tbl_wstrb;
  logic [31:0] tbl_wdata;
  logic        tbl_ready;
  logic [31:0] tbl_rdata;

  lut_table_loader #(.DATA_W(32), .SRC_ADDR_W(32), .TBL_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       (base),
    .busy       (busy),
    .done       (done),
    .run        (run),
    .src_valid  (src_valid),
    .src_addr   (src_addr),
    .src_ready  (src_ready),
    .src_rdata  (src_rdata),
    .host_valid (host_valid),
    .host_addr  (host_addr),
    .host_wstrb (host_wstrb),
    .host_wdata (host_wdata),
    .host_ready (host_ready),
    .host_rdata (host_rdata),
    .tbl_valid  (tbl_valid),
    .tbl_addr   (tbl_addr),
    .tbl_wstrb  (tbl_wstrb),
    .tbl_wdata  (tbl_wdata),
    .tbl_ready  (tbl_ready),
    .tbl_rdata  (tbl_rdata)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [8:0]  wr_addr [512];
  logic [31:0] wr_data [512];
  logic [31:0] src_log [512];
  int n_wr, n_rd, done_cnt, done_cyc, first_src, cyc, wmax;
  int stab_bad, run_bad, host_bad, host_done_cyc;
  logic [31:0] cur_base;
  bit src_pend, tbl_pend, host_clear;
  int src_w, tbl_w;
  logic [31:0] src_hold;
  logic [44:0] tbl_hold;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: release one-shot inputs, respond to requests, observe.
  task automatic tick();
    @(negedge clk);
    cyc++;
    start = 1'b0;
    if (host_clear) begin
      host_valid = 1'b0;
      host_clear = 1'b0;
    end
    #1;
    src_ready = 1'b0;
    src_rdata = 32'h0BAD0BAD;
    if (src_valid) begin
      if (!src_pend) begin
        src_pend = 1'b1;
        src_w    = (wmax > 0) ? $urandom_range(0, wmax) : 0;
        src_hold = src_addr;
      end else if (src_addr !== src_hold) stab_bad++;
      if (src_w == 0) begin
        src_ready = 1'b1;
        src_rdata = 32'hA500_0000 | ((src_addr - cur_base) >> 2);
        src_pend  = 1'b0;
        if (n_rd < 512) src_log[n_rd] = src_addr;
        n_rd++;
      end else src_w--;
    end else begin
      src_pend = 1'b0;
      if (wmax > 0 && busy) src_ready = 1'($urandom_range(0, 1));
    end
    tbl_ready = 1'b0;
    tbl_rdata = 32'h1234_5678;
    if (tbl_valid) begin
      if (!tbl_pend) begin
        tbl_pend = 1'b1;
        tbl_w    = (wmax > 0) ? $urandom_range(0, wmax) : 0;
        tbl_hold = {tbl_addr, tbl_wstrb, tbl_wdata};
      end else if ({tbl_addr, tbl_wstrb, tbl_wdata} !== tbl_hold) stab_bad++;
      if (tbl_w == 0) begin
        tbl_ready = 1'b1;
        tbl_pend  = 1'b0;
      end else tbl_w--;
    end else begin
      tbl_pend = 1'b0;
      if (wmax > 0 && busy) tbl_ready = 1'($urandom_range(0, 1));
    end
    #1;
    if (busy && tbl_valid && tbl_ready) begin
      if (n_wr < 512) begin
        wr_addr[n_wr] = tbl_addr;
        wr_data[n_wr] = tbl_wdata;
      end
      n_wr++;
    end
    if (src_valid && first_src < 0) first_src = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (run !== done) run_bad++;
    if (busy && (host_ready !== 1'b0 || host_rdata !== 32'h0)) host_bad++;
    if (host_valid && host_ready && !host_clear) begin
      host_done_cyc = cyc;
      host_clear    = 1'b1;
    end
  endtask

  task automatic host_req();
    host_valid = 1'b1;
    host_addr  = 9'h105;
    host_wstrb = 4'hF;
    host_wdata = 32'hDEAD_BEEF;
  endtask

  task automatic run_load(input logic [31:0] b, input int wm, input int again_at,
                          input int rst_at, input int host_at, input bit host_w_start);
    bit again_done = 1'b0;
    bit host_done  = 1'b0;
    int guard      = 0;
    int tail       = 0;
    cur_base = b; wmax = wm;
    n_wr = 0; n_rd = 0; done_cnt = 0; done_cyc = -1; first_src = -1;
    stab_bad = 0; run_bad = 0; host_bad = 0; host_done_cyc = -1;
    tick();
    start = 1'b1;
    base  = b;
    cyc   = 0;
    if (host_w_start) begin
      host_req();
      tbl_ready = 1'b1;
      tbl_rdata = 32'hCAFE_F00D;
      #1;
      chk("host_with_start", {host_ready, tbl_valid, tbl_addr, host_rdata},
          {1'b1, 1'b1, 9'h105, 32'hCAFE_F00D});
      host_clear = 1'b1;
    end
    while (guard < 20000) begin
      guard++;
      tick();
      if (n_wr == again_at && !again_done) begin
        start      = 1'b1;
        again_done = 1'b1;
      end
      if (n_wr == host_at && !host_done) begin
        host_req();
        host_done = 1'b1;
      end
      if (n_wr == rst_at) begin
        rst = 1'b0;
        #1;
        chk("abort_ctl", {busy, done, run, src_valid}, 4'b0000);
        chk("abort_addr", src_addr, 32'h0);
        chk("abort_tbl_mirror", {tbl_valid, tbl_addr}, {host_valid, host_addr});
        repeat (4) tick();
        rst = 1'b1;
        src_pend = 1'b0;
        tbl_pend = 1'b0;
        break;
      end
      if (done_cnt > 0 && (!host_valid || host_clear)) begin
        tail++;
        if (tail > 4) break;
      end
    end
    if (guard >= 20000) chk("timeout", 1, 0);
  endtask

  task automatic verify(input string tag, input logic [31:0] b, input int exp_done);
    int bad = 0;
    for (int n = 0; n < 512; n++) begin
      logic [8:0] nn;
      nn = 9'(n);
      if (wr_addr[n] !== {~nn[8], nn[7:0]} || wr_data[n] !== (32'hA500_0000 | 32'(n)) ||
          src_log[n] !== b + 32'(4 * n)) bad++;
    end
    chk({tag, " writes"}, n_wr, 512);
    chk({tag, " done_count"}, done_cnt, 1);
    chk({tag, " first_src_cycle"}, first_src, 1);
    if (exp_done > 0) chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " sequence_errors"}, bad, 0);
    chk({tag, " request_changes"}, stab_bad, 0);
    chk({tag, " run_vs_done"}, run_bad, 0);
    chk({tag, " host_leak"}, host_bad, 0);
    chk({tag, " t0_idx0"}, {wr_addr[0], wr_data[0]}, {9'h100, 32'hA500_0000});
    chk({tag, " t1_idx255"}, {wr_addr[511], wr_data[511]}, {9'h0FF, 32'hA500_01FF});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base = 32'h0;
    src_ready = 1'b0; src_rdata = 32'h0;
    tbl_ready = 1'b0; tbl_rdata = 32'h0;
    host_valid = 1'b0; host_addr = 9'h0; host_wstrb = 4'h0; host_wdata = 32'h0;
    src_pend = 1'b0; tbl_pend = 1'b0; host_clear = 1'b0;
    wmax = 0; cyc = 0; cur_base = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {busy, done, run, src_valid}, 4'b0000);
    chk("reset_addr", src_addr, 32'h0);
    rst = 1'b1;

    // Idle passthrough, with the datapath first stalling then accepting.
    @(negedge clk);
    host_req();
    tbl_ready = 1'b0;
    tbl_rdata = 32'h5A5A_0001;
    #1;
    chk("pass_req", {tbl_valid, tbl_addr, tbl_wstrb, tbl_wdata, host_ready},
        {1'b1, 9'h105, 4'hF, 32'hDEAD_BEEF, 1'b0});
    tbl_ready = 1'b1;
    #1;
    chk("pass_rsp", {host_ready, host_rdata}, {1'b1, 32'h5A5A_0001});
    host_valid = 1'b0;
    tbl_ready  = 1'b0;

    run_load(32'h0000_1000, 0, -1, -1, -1, 1'b0);
    verify("zero_wait", 32'h0000_1000, 1025);

    run_load(32'h0000_1000, 5, -1, -1, -1, 1'b0);
    verify("random_wait", 32'h0000_1000, -1);

    run_load(32'h0000_1000, 0, -1, -1, 10, 1'b1);
    verify("host_stall", 32'h0000_1000, 1025);
    chk("host_stall_complete_cycle", host_done_cyc, 1026);

    run_load(32'h0000_1000, 0, 100, -1, -1, 1'b0);
    verify("restart_ignored", 32'h0000_1000, 1025);

    run_load(32'h0000_1000, 0, -1, 300, -1, 1'b0);
    chk("abort_writes", n_wr, 300);
    chk("abort_no_done", done_cnt, 0);

    run_load(32'h0000_1000, 0, -1, -1, -1, 1'b0);
    verify("after_abort", 32'h0000_1000, 1025);
    chk("after_abort_first_addr", src_log[0], 32'h0000_1000);

    run_load(32'hFFFF_FFF0, 0, -1, -1, -1, 1'b0);
    verify("wrap", 32'hFFFF_FFF0, 1025);
    chk("wrap_word4_addr", src_log[4], 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
